// File: rtl/ma_pkg.sv
// Shared constants and types for the Montgomery-multiply scheduler.
package ma_pkg;
   localparam int MA_W        = 1040;
   localparam int MA_PH_W     = 65;
   localparam int MA_OUT_W    = 1041;
   localparam int DEF_TIMEOUT = 512;
   localparam int DEF_GUARD   = 2;

   typedef enum logic [2:0] {IDLE, GRANT, START, WAIT, RESP} state_t;

   // Index width for a requester count, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/ma_sched_if.sv
// Bus bundle between the scheduler, its front-end requesters and the ma core.
interface ma_sched_if import ma_pkg::*; #(
   parameter int NREQ = 2
) ();
   localparam int IDW = idx_w(NREQ);

   logic                           cfg_we;
   logic [MA_W-1:0]                cfg_p;
   logic [MA_PH_W-1:0]             cfg_ph;
   logic                           cfg_busy;
   logic [NREQ-1:0]                req_valid;
   logic [NREQ-1:0]                req_ready;
   logic [NREQ-1:0][MA_W-1:0]      req_a;
   logic [NREQ-1:0][MA_W-1:0]      req_b;
   logic                           rsp_valid;
   logic                           rsp_ready;
   logic [IDW-1:0]                 rsp_id;
   logic [MA_OUT_W-1:0]            rsp_c;
   logic                           rsp_err;
   logic                           ma_start;
   logic [MA_W-1:0]                ma_a;
   logic [MA_W-1:0]                ma_b;
   logic [MA_W-1:0]                ma_p;
   logic [MA_PH_W-1:0]             ma_ph;
   logic [MA_OUT_W-1:0]            ma_c;
   logic                           ma_ready;

   // Scheduler side.
   modport master (
      input  cfg_we, cfg_p, cfg_ph, req_valid, req_a, req_b, rsp_ready, ma_c, ma_ready,
      output cfg_busy, req_ready, rsp_valid, rsp_id, rsp_c, rsp_err,
             ma_start, ma_a, ma_b, ma_p, ma_ph
   );

   // Front-ends plus core side.
   modport slave (
      output cfg_we, cfg_p, cfg_ph, req_valid, req_a, req_b, rsp_ready, ma_c, ma_ready,
      input  cfg_busy, req_ready, rsp_valid, rsp_id, rsp_c, rsp_err,
             ma_start, ma_a, ma_b, ma_p, ma_ph
   );
endinterface

// File: rtl/ma_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx,
   output logic            any
);
   // Scan farthest offset first so the request nearest to ptr overrides.
   always_comb begin
      int j;
      j   = 0;
      gnt = '0;
      idx = '0;
      any = |req;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % NREQ;
         if (req[j]) begin
            gnt    = '0;
            gnt[j] = 1'b1;
            idx    = IDW'(j);
         end
      end
   end
endmodule

// File: rtl/ma_sched.sv
// Shares one Montgomery multiply core between NREQ requesters: holds P/PH,
// grants jobs round-robin, runs the core with a ready timeout, returns a
// tagged result.
module ma_sched import ma_pkg::*; #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int GUARD   = DEF_GUARD
) (
   input  logic          clk,
   input  logic          rst,
   ma_sched_if.master    bus
);
   localparam int IDW = idx_w(NREQ);
   localparam int CW  = $clog2(TIMEOUT + 1);

   state_t              state;
   logic [IDW-1:0]      ptr;
   logic [IDW-1:0]      id_q;
   logic [MA_W-1:0]     p_q, a_q, b_q;
   logic [MA_PH_W-1:0]  ph_q;
   logic [MA_OUT_W-1:0] c_q;
   logic                err_q, start_q, busy_q, rsp_v_q;
   logic [CW-1:0]       cnt;
   logic [NREQ-1:0]     gnt;
   logic [IDW-1:0]      gidx;
   logic                any;
   logic                take;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req (bus.req_valid),
      .ptr (ptr),
      .gnt (gnt),
      .idx (gidx),
      .any (any)
   );

   // Config write wins over a pending request; accept is a same-cycle pulse.
   assign take          = (state == IDLE) && !bus.cfg_we && any && !rst;
   assign bus.req_ready = take ? gnt : '0;

   // Core operands come straight from the latched registers, so they stay
   // frozen from GRANT through WAIT (config and requests are blocked then).
   assign bus.ma_a     = a_q;
   assign bus.ma_b     = b_q;
   assign bus.ma_p     = p_q;
   assign bus.ma_ph    = ph_q;
   assign bus.ma_start = start_q;
   assign bus.cfg_busy = busy_q;
   assign bus.rsp_valid = rsp_v_q;
   assign bus.rsp_id   = id_q;
   assign bus.rsp_c    = c_q;
   assign bus.rsp_err  = err_q;

   // Job FSM with registered outputs; reset drops any in-flight job silently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         id_q    <= '0;
         p_q     <= '0;
         ph_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         rsp_v_q <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cfg_we) begin
                  p_q  <= bus.cfg_p;
                  ph_q <= bus.cfg_ph;
               end else if (any) begin
                  a_q    <= bus.req_a[gidx];
                  b_q    <= bus.req_b[gidx];
                  id_q   <= gidx;
                  ptr    <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
                  busy_q <= 1'b1;
                  state  <= GRANT;
               end
            end
            GRANT: begin
               start_q <= 1'b1;
               state   <= START;
            end
            START: begin
               start_q <= 1'b0;
               cnt     <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               // Stale ready from a previous (possibly aborted) job is masked
               // for the first GUARD cycles; ready beats timeout on a tie.
               if (cnt >= CW'(GUARD) && bus.ma_ready) begin
                  c_q     <= bus.ma_c;
                  err_q   <= 1'b0;
                  rsp_v_q <= 1'b1;
                  state   <= RESP;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  c_q     <= '0;
                  err_q   <= 1'b1;
                  rsp_v_q <= 1'b1;
                  state   <= RESP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RESP: begin
               if (rsp_v_q && bus.rsp_ready) begin
                  rsp_v_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ma_sched.sv
// Bench for ma_sched: stub core, transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ma_sched;
   import ma_pkg::*;

   localparam int NR = 3;
   localparam int TO = 512;
   localparam int GD = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ma_sched_if #(.NREQ(NR)) bus ();

   ma_sched #(.NREQ(NR), .TIMEOUT(TO), .GUARD(GD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- stub core ----------------
   int   stub_d     = 10;
   logic stub_never = 1'b0;
   logic stale      = 1'b0;
   logic running    = 1'b0;
   int   sc         = 0;
   logic stale_on;

   always @(posedge clk) begin
      if (bus.ma_start) begin
         running <= 1'b1;
         sc      <= 0;
      end else if (running) begin
         if (!stub_never && sc == stub_d - 1) running <= 1'b0;
         sc <= sc + 1;
      end
   end

   always_comb begin
      stale_on     = stale && (!running || sc < GD);
      bus.ma_ready = stale_on || (running && !stub_never && sc == stub_d - 1);
      bus.ma_c     = stale_on ? MA_OUT_W'(12'h5A5) : ({1'b0, bus.ma_a} + {1'b0, bus.ma_b});
   end

   // ---------------- bookkeeping ----------------
   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int left [NR];

   // model state
   logic                m_busy = 1'b0;
   int                  m_ptr = 0;
   logic [MA_W-1:0]     m_p = '0, m_a = '0, m_b = '0;
   logic [MA_PH_W-1:0]  m_ph = '0;
   int                  m_id = 0, m_grant_cyc = 0, m_start_cyc = 0, m_rsp_cyc = 0;
   logic [MA_OUT_W-1:0] m_c = '0;
   logic                m_err = 1'b0;

   // observed records
   logic [NR-1:0]       last_gnt = '0;
   int                  gl [$];
   int                  n_gnt = 0, n_hs = 0, gcyc = 0, act_start = 0;
   int                  rv_first = 0, rv_cnt = 0;
   logic                prev_rv = 1'b0;
   int                  act_id = 0;
   logic [MA_OUT_W-1:0] act_c = '0;
   logic                act_err = 1'b0;

   task automatic chk(input string nm, input logic [MA_OUT_W-1:0] act,
                      input logic [MA_OUT_W-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h want %0h (low 64b) at cycle %0d",
                  nm, act[63:0], exp[63:0], cyc);
      end
   endtask

   // Per-cycle comparison against the transaction model, then model advance.
   task automatic check_cycle();
      logic [NR-1:0] exp_rr;
      int            g;
      logic          due;
      exp_rr = '0;
      g      = -1;
      if (rst) begin
         chk("rst_req_ready", bus.req_ready, 0);
         chk("rst_cfg_busy",  bus.cfg_busy, 0);
         chk("rst_rsp_valid", bus.rsp_valid, 0);
         chk("rst_rsp_id",    bus.rsp_id, 0);
         chk("rst_rsp_c",     bus.rsp_c, 0);
         chk("rst_rsp_err",   bus.rsp_err, 0);
         chk("rst_ma_start",  bus.ma_start, 0);
         chk("rst_ma_a",      bus.ma_a, 0);
         chk("rst_ma_b",      bus.ma_b, 0);
         chk("rst_ma_p",      bus.ma_p, 0);
         chk("rst_ma_ph",     bus.ma_ph, 0);
         m_busy   = 1'b0;
         m_ptr    = 0;
         m_p      = '0;
         m_ph     = '0;
         last_gnt = '0;
         prev_rv  = 1'b0;
         return;
      end
      if (!m_busy && !bus.cfg_we)
         for (int k = 0; k < NR; k++)
            if (g < 0 && bus.req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
      if (g >= 0) exp_rr[g] = 1'b1;
      chk("req_ready", bus.req_ready, exp_rr);
      chk("cfg_busy",  bus.cfg_busy, m_busy);
      chk("ma_start",  bus.ma_start, m_busy && cyc == m_start_cyc);
      due = m_busy && cyc >= m_rsp_cyc;
      chk("rsp_valid", bus.rsp_valid, due);
      if (due) begin
         chk("rsp_id",  bus.rsp_id, m_id);
         chk("rsp_c",   bus.rsp_c, m_c);
         chk("rsp_err", bus.rsp_err, m_err);
      end
      if (m_busy && cyc > m_grant_cyc) begin
         chk("ma_a",  bus.ma_a, m_a);
         chk("ma_b",  bus.ma_b, m_b);
         chk("ma_p",  bus.ma_p, m_p);
         chk("ma_ph", bus.ma_ph, m_ph);
      end
      // observed events
      last_gnt = bus.req_ready;
      for (int i = 0; i < NR; i++)
         if (bus.req_ready[i]) begin
            gl.push_back(i);
            n_gnt++;
            gcyc = cyc;
         end
      if (bus.ma_start) act_start = cyc;
      if (bus.rsp_valid) begin
         if (!prev_rv) begin
            rv_first = cyc;
            rv_cnt   = 0;
         end
         rv_cnt++;
         if (bus.rsp_ready) begin
            act_id  = int'(bus.rsp_id);
            act_c   = bus.rsp_c;
            act_err = bus.rsp_err;
            n_hs++;
         end
      end
      prev_rv = bus.rsp_valid;
      // model advance
      if (g >= 0) begin
         m_busy      = 1'b1;
         m_id        = g;
         m_a         = bus.req_a[g];
         m_b         = bus.req_b[g];
         m_ptr       = (g + 1) % NR;
         m_grant_cyc = cyc;
         m_start_cyc = cyc + 2;
         m_rsp_cyc   = stub_never ? cyc + 3 + TO : cyc + 3 + stub_d;
         m_err       = stub_never;
         m_c         = stub_never ? '0 : ({1'b0, m_a} + {1'b0, m_b});
      end else if (!m_busy && bus.cfg_we) begin
         m_p  = bus.cfg_p;
         m_ph = bus.cfg_ph;
      end
      if (due && bus.rsp_ready) m_busy = 1'b0;
   endtask

   // One clock: compare mid-cycle, then update requesters just after the edge.
   task automatic tick();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < NR; i++)
         if (last_gnt[i]) begin
            if (left[i] > 1) begin
               left[i]--;
               bus.req_a[i] = bus.req_a[i] + MA_W'(16);
            end else begin
               left[i]          = 0;
               bus.req_valid[i] = 1'b0;
            end
         end
   endtask

   task automatic job(input int i, input int a, input int b, input int n);
      bus.req_a[i]     = MA_W'(a);
      bus.req_b[i]     = MA_W'(b);
      left[i]          = n;
      bus.req_valid[i] = 1'b1;
   endtask

   task automatic wait_hs(input int target, input int budget);
      int k;
      k = 0;
      while (n_hs < target && k < budget) begin
         tick();
         k++;
      end
      chk("wait_rsp_handshake", n_hs >= target, 1);
   endtask

   task automatic wait_gnt(input int target, input int budget);
      int k;
      k = 0;
      while (n_gnt < target && k < budget) begin
         tick();
         k++;
      end
      chk("wait_grant", n_gnt >= target, 1);
   endtask

   initial begin
      int base, cfgcyc, hs0, k;
      int exp_order [4];
      exp_order = '{1, 0, 1, 0};
      for (int i = 0; i < NR; i++) left[i] = 0;
      rst           = 1'b1;
      bus.cfg_we    = 1'b0;
      bus.cfg_p     = '0;
      bus.cfg_ph    = '0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b1;
      stale         = 1'b1;     // ready high before the first start
      repeat (3) tick();
      rst = 1'b0;
      chk("post_rst_busy", bus.cfg_busy, 0);
      chk("post_rst_rsp_valid", bus.rsp_valid, 0);

      // single job
      bus.cfg_we = 1'b1;
      bus.cfg_p  = MA_W'(3);
      bus.cfg_ph = MA_PH_W'(1);
      tick();
      bus.cfg_we = 1'b0;
      stub_d = 10;
      job(0, 5, 7, 1);
      wait_hs(n_hs + 1, 100);
      chk("single_gnt_id", gl[0], 0);
      chk("single_start_lat", act_start - gcyc, 2);
      chk("single_rsp_lat", rv_first - gcyc, 13);
      chk("single_c", act_c, 12);
      chk("single_id", act_id, 0);
      chk("single_err", act_err, 0);
      stale = 1'b0;

      // round-robin: ptr sits at 1 after the first job
      stub_d = 6;
      base = gl.size();
      job(0, 'h100, 1, 2);
      job(1, 'h200, 2, 2);
      wait_hs(n_hs + 4, 200);
      for (int i = 0; i < 4; i++) chk("rr_order", gl[base + i], exp_order[i]);

      // ready exactly at the guard boundary
      stub_d = GD + 1;
      job(1, 1, 1, 1);
      wait_hs(n_hs + 1, 50);
      chk("guard_edge_lat", rv_first - gcyc, 6);
      chk("guard_edge_c", act_c, 2);

      // timeout, then a normal job
      stub_never = 1'b1;
      job(0, 2, 3, 1);
      wait_hs(n_hs + 1, TO + 50);
      chk("to_err", act_err, 1);
      chk("to_c", act_c, 0);
      chk("to_lat", rv_first - act_start, TO + 1);
      stub_never = 1'b0;
      stub_d = 10;
      job(1, 'h10, 'h20, 1);
      wait_hs(n_hs + 1, 50);
      chk("after_to_err", act_err, 0);
      chk("after_to_c", act_c, 'h30);

      // ready on the last allowed cycle beats timeout
      stub_d = TO;
      job(2, 4, 4, 1);
      wait_hs(n_hs + 1, TO + 50);
      chk("tie_err", act_err, 0);
      chk("tie_lat", rv_first - act_start, TO + 1);

      // back-pressure, cfg lock, request dropped before grant
      stub_d = 40;
      bus.rsp_ready = 1'b0;
      job(0, 0, 'h77, 1);
      wait_gnt(n_gnt + 1, 20);
      base = gl.size();
      bus.req_a[2] = MA_W'('h55);
      bus.req_b[2] = MA_W'('h66);
      bus.req_valid[2] = 1'b1;
      repeat (3) tick();
      bus.req_valid[2] = 1'b0;
      repeat (2) tick();
      bus.cfg_we = 1'b1;
      bus.cfg_p  = MA_W'(9);
      tick();
      bus.cfg_we = 1'b0;
      chk("cfg_locked_p", bus.ma_p, 3);
      k = 0;
      while (!bus.rsp_valid && k < 100) begin
         tick();
         k++;
      end
      chk("bp_rsp_reached", bus.rsp_valid, 1);
      repeat (20) tick();
      bus.rsp_ready = 1'b1;
      wait_hs(n_hs + 1, 10);
      chk("bp_valid_cycles", rv_cnt, 21);
      chk("bp_c", act_c, 'h77);
      chk("drop_no_grant", gl.size(), base);

      // config in IDLE alongside a request: config first, grant next cycle
      stub_d = 10;
      bus.cfg_we = 1'b1;
      bus.cfg_p  = MA_W'('h11);
      job(1, 8, 9, 1);
      cfgcyc = cyc;
      tick();
      bus.cfg_we = 1'b0;
      wait_gnt(n_gnt + 1, 10);
      chk("cfg_then_grant", gcyc - cfgcyc, 1);
      chk("cfg_new_p", bus.ma_p, 'h11);
      wait_hs(n_hs + 1, 50);

      // reset 50 cycles into WAIT
      stub_d = 100;
      job(0, 'h33, 1, 1);
      wait_gnt(n_gnt + 1, 10);
      hs0 = n_hs;
      repeat (52) tick();
      rst = 1'b1;
      #1;
      chk("rst_now_busy", bus.cfg_busy, 0);
      chk("rst_now_ma_a", bus.ma_a, 0);
      repeat (2) tick();
      rst = 1'b0;
      chk("rst_no_rsp", n_hs, hs0);
      // pointer back at 0; stale ready inside guard must be ignored
      stale  = 1'b1;
      stub_d = 8;
      bus.cfg_we = 1'b1;
      bus.cfg_p  = MA_W'(3);
      tick();
      bus.cfg_we = 1'b0;
      base = gl.size();
      job(0, 'h40, 2, 1);
      job(1, 'h50, 3, 1);
      wait_hs(n_hs + 2, 100);
      chk("rst_ptr_first", gl[base], 0);
      chk("stale_ignored_c", act_c, 'h53);
      stale = 1'b0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
